fft_core_param: RTL
===================

// Module: fft_core_param
// PURPOSE
//  Parametrised iterative radix-2 DIT FFT/IFFT core; next generation of the fixed 64-point FFT.
//  Samples stream in and out over valid/ready; a start/busy/done handshake frames each run.
//  Adds a run-time inverse mode and per-stage 1/2 scaling, so the output is X[k]/N.
//  Sits between the sample capture front-end and the spectral post-processing logic.
// PARAMETERS
//  N_POINTS  64  transform size; power of two, 8..1024
//  DATA_W    16  signed two's-complement width of each re/im sample
//  TW_W      16  signed twiddle width, Q1.(TW_W-1)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous reset, active-low
//  start      in   1       begin a run; sampled only in IDLE
//  inverse    in   1       0=forward FFT, 1=IFFT (conjugate twiddles); latched with start
//  in_valid   in   1       input sample valid
//  in_ready   out  1       core accepts input (LOAD state only)
//  in_re      in   DATA_W  input real part, natural order x[0..N-1]
//  in_im      in   DATA_W  input imaginary part
//  out_valid  out  1       output sample valid
//  out_ready  in   1       downstream accepts output
//  out_re     out  DATA_W  output real part, natural order X[0..N-1]
//  out_im     out  DATA_W  output imaginary part
//  busy       out  1       high in LOAD, COMPUTE and UNLOAD
//  done       out  1       one-cycle pulse in the cycle after the last output handshake
// BEHAVIOUR
//  Reset (rst=0): state IDLE; in_ready, out_valid, busy, done, out_re, out_im all 0; counters 0.
//   Reset mid-run aborts immediately and produces no done; sample memory contents are don't-care.
//  FSM: IDLE -start-> LOAD -N accepts-> COMPUTE -last butterfly-> UNLOAD -N handshakes-> IDLE.
//   start outside IDLE is ignored. inverse is captured on the start cycle.
//  LOAD: in_ready=1. A sample is written on in_valid&in_ready to mem[bitrev(idx)], then idx++.
//   The transition to COMPUTE occurs on the cycle after the accept of idx=N-1.
//  COMPUTE: LOG2N stages x N/2 butterflies, one butterfly per cycle, in place.
//   Latency is exactly LOG2N*N/2 cycles (192 for N=64). in_ready=0 and out_valid=0 throughout.
//   Stage s (0..LOG2N-1): span=2^s; twiddle index k=(j mod span)*(N/(2*span)).
//   Twiddle W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N); imaginary part is negated when inverse=1.
//  Butterfly: t = b*W. Use the full-precision product, add 2^(TW_W-2), then >>> (TW_W-1).
//   a' = (a+t+1)>>>1, b' = (a-t+1)>>>1, computed in DATA_W+2 bits.
//   Each result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  Twiddle cos(0)=1.0 saturates to 2^(TW_W-1)-1.
//  UNLOAD: out_re/out_im are registered from mem[oidx], with oidx starting at 0.
//   Output is held stable while out_valid & !out_ready.
//   On handshake, oidx++ and the next value is loaded in the next cycle, so there are no bubbles.
//   After the handshake of oidx=N-1: out_valid=0, done=1 for one cycle, state IDLE.
//   out_re/out_im keep their last value while in IDLE.
//  Back-to-back: start may be asserted in the same cycle that done is high; the IDLE visit is 1 cycle.
// STRUCTURE
//  Package fft_pkg: state_t enum {IDLE,LOAD,COMPUTE,UNLOAD}.
//   Also holds the bitrev() function and the twiddle_rom() constant function, which builds the
//   N_POINTS/2-entry cos/sin table at elaboration.
//  Sub-module fft_butterfly: a 1-cycle registered complex butterfly holding the rounding and
//   saturation rules above; parameters DATA_W and TW_W.
//  Top level: FSM, counters, stage and twiddle addressing, N x 2*DATA_W register-array memory.
// TESTING
//  1 Impulse: N=64, x[0]=0x4000, all others 0, forward -> all X[k]=0x0100 re, 0 im;
//    done 1 cycle after the 64th out handshake.
//  2 DC: all x=0x0400+j0 -> X[0]=0x0400, X[1..63]=0 exactly.
//  3 Tone: x[n]=round(16384*cos(2*pi*n/64)) -> X[1], X[63] = 8192 +/-2 LSB re;
//    every other bin within +/-2 LSB of 0.
//  4 Inverse: all inputs 0x0100+j0 with inverse=1 -> X[0]=0x0100, others 0.
//    Also: forward then inverse of test 3's output gives x[n]/64 within +/-2 LSB.
//  5 Handshake: random in_valid gaps and out_ready low for 5 cycles mid-unload.
//    -> no lost or duplicated samples; output held stable during stalls.
//    -> COMPUTE lasts exactly 192 cycles; start pulsed during busy is ignored.
//  6 Reset: rst=0 in COMPUTE and in UNLOAD.
//    -> all outputs 0 immediately, no done; a following run gives correct test-1 results.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the radix-2 FFT core:
// FSM state encoding, index bit reversal and the twiddle table generator.
package fft_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;

   // Reverse the low 'bits' bits of v (input reordering for in-place DIT).
   function automatic int bitrev(input int v, input int bits);
      int r;
      r = 0;
      for (int i = 0; i < bits; i++) begin
         r = (r << 1) | ((v >> i) & 1);
      end
      return r;
   endfunction

   // One entry of the N/2-entry twiddle table: round(cos or sin(2*pi*k/n))
   // in Q1.(tw_w-1). The value 1.0 is not representable, so it clamps to max.
   function automatic int twiddle_rom(input int k, input int n, input int tw_w,
                                      input bit want_sin);
      real ang;
      real v;
      int  r;
      int  lim;
      ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(n);
      v   = (want_sin ? $sin(ang) : $cos(ang)) * real'(1 << (tw_w - 1));
      r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
      lim = (1 << (tw_w - 1)) - 1;
      if (r > lim) r = lim;
      if (r < -lim - 1) r = -lim - 1;
      return r;
   endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Registered radix-2 DIT butterfly with a 1/2 scale on both outputs:
//   t = round(b*W), a' = sat((a+t+1)>>>1), b' = sat((a-t+1)>>>1).
module fft_butterfly
   import fft_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int TW_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     vld_p0,
   input  logic signed [DATA_W-1:0] a_re_p0,
   input  logic signed [DATA_W-1:0] a_im_p0,
   input  logic signed [DATA_W-1:0] b_re_p0,
   input  logic signed [DATA_W-1:0] b_im_p0,
   input  logic signed [TW_W-1:0]   w_re_p0,
   input  logic signed [TW_W-1:0]   w_im_p0,
   output logic                     vld_p1,
   output logic signed [DATA_W-1:0] a_re_p1,
   output logic signed [DATA_W-1:0] a_im_p1,
   output logic signed [DATA_W-1:0] b_re_p1,
   output logic signed [DATA_W-1:0] b_im_p1
);

   localparam int PW = DATA_W + TW_W + 1;
   localparam int EW = DATA_W + 2;
   localparam logic signed [PW-1:0] RND_K = PW'(1) <<< (TW_W - 2);
   localparam logic signed [EW-1:0] ONE_E = EW'(1);
   localparam logic signed [EW-1:0] MAX_E = EW'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [EW-1:0] MIN_E = -MAX_E - ONE_E;

   logic signed [PW-1:0] p_re, p_im;
   logic signed [EW-1:0] t_re, t_im;

   // Round the full-precision product back to data scale (round half up).
   function automatic logic signed [EW-1:0] round_tw(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] r;
      r = (p + RND_K) >>> (TW_W - 1);
      return r[EW-1:0];
   endfunction

   // Halve with rounding, then clamp to the DATA_W signed range.
   function automatic logic signed [DATA_W-1:0] halve_sat(input logic signed [EW-1:0] v);
      logic signed [EW-1:0] h;
      logic signed [EW-1:0] c;
      h = (v + ONE_E) >>> 1;
      c = h;
      if (h > MAX_E) c = MAX_E;
      if (h < MIN_E) c = MIN_E;
      return c[DATA_W-1:0];
   endfunction

   // Complex product b*W at full precision, then rounded.
   always_comb begin
      p_re = PW'(b_re_p0) * PW'(w_re_p0) - PW'(b_im_p0) * PW'(w_im_p0);
      p_im = PW'(b_re_p0) * PW'(w_im_p0) + PW'(b_im_p0) * PW'(w_re_p0);
      t_re = round_tw(p_re);
      t_im = round_tw(p_im);
   end

   // ---- p0 -> p1: butterfly results registered ----
   always_ff @(posedge clk) begin
      a_re_p1 <= halve_sat(EW'(a_re_p0) + t_re);
      a_im_p1 <= halve_sat(EW'(a_im_p0) + t_im);
      b_re_p1 <= halve_sat(EW'(a_re_p0) - t_re);
      b_im_p1 <= halve_sat(EW'(a_im_p0) - t_im);
   end

   // Valid travels with the data through the single register stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_p1 <= 1'b0;
      else      vld_p1 <= vld_p0;
   end

endmodule

// File: rtl/fft_core_param.sv
// Iterative in-place radix-2 DIT FFT/IFFT with per-stage 1/2 scaling.
// Samples load in bit-reversed order, one butterfly runs per cycle, and
// results stream out in natural order over valid/ready.
module fft_core_param
   import fft_pkg::*;
#(
   parameter int N_POINTS = 64,
   parameter int DATA_W   = 16,
   parameter int TW_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     inverse,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_re,
   input  logic signed [DATA_W-1:0] in_im,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_re,
   output logic signed [DATA_W-1:0] out_im,
   output logic                     busy,
   output logic                     done
);

   localparam int LOG2N = $clog2(N_POINTS);
   localparam int AW    = LOG2N;
   localparam int JW    = LOG2N - 1;
   localparam int SW    = $clog2(LOG2N);
   localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);
   localparam logic [JW-1:0] LAST_J   = JW'(N_POINTS / 2 - 1);
   localparam logic [SW-1:0] LAST_S   = SW'(LOG2N - 1);

   state_t state, state_nx;
   logic              inv_q;
   logic [AW-1:0]     load_idx, out_idx, br_idx;
   logic [AW-1:0]     a_idx, b_idx, span, pos;
   logic [SW-1:0]     s_cnt;
   logic [JW-1:0]     j_cnt, tw_idx;
   logic              load_fire, out_fire, last_bf;
   logic signed [DATA_W-1:0] mem_re [N_POINTS];
   logic signed [DATA_W-1:0] mem_im [N_POINTS];
   logic signed [TW_W-1:0]   tw_cos [N_POINTS/2];
   logic signed [TW_W-1:0]   tw_sin [N_POINTS/2];
   logic signed [TW_W-1:0]   w_im;
   logic              vld_p0, vld_p1;
   logic [AW-1:0]     wa_p1, wb_p1;
   logic signed [DATA_W-1:0] ar_p1, ai_p1, br_p1, bi_p1;

   for (genvar g = 0; g < N_POINTS / 2; g++) begin : g_tw
      localparam int COS_V = twiddle_rom(g, N_POINTS, TW_W, 1'b0);
      localparam int SIN_V = twiddle_rom(g, N_POINTS, TW_W, 1'b1);
      assign tw_cos[g] = TW_W'(COS_V);
      assign tw_sin[g] = TW_W'(SIN_V);
   end

   assign load_fire = (state == LOAD) && in_valid;
   assign out_fire  = out_valid && out_ready;
   assign last_bf   = (s_cnt == LAST_S) && (j_cnt == LAST_J);
   assign br_idx    = AW'(bitrev(int'(load_idx), LOG2N));
   assign vld_p0    = (state == COMPUTE);

   // Butterfly addressing: pairs are span apart within groups of 2*span.
   always_comb begin
      span   = AW'(1) << s_cnt;
      pos    = AW'(j_cnt) & (span - 1'b1);
      a_idx  = (((AW'(j_cnt) >> s_cnt) << s_cnt) << 1) | pos;
      b_idx  = a_idx | span;
      tw_idx = JW'(pos << (LAST_S - s_cnt));
      w_im   = inv_q ? tw_sin[tw_idx] : -tw_sin[tw_idx];
   end

   fft_butterfly #(.DATA_W(DATA_W), .TW_W(TW_W)) u_bf (
      .clk     (clk),
      .rst     (rst),
      .vld_p0  (vld_p0),
      .a_re_p0 (mem_re[a_idx]),
      .a_im_p0 (mem_im[a_idx]),
      .b_re_p0 (mem_re[b_idx]),
      .b_im_p0 (mem_im[b_idx]),
      .w_re_p0 (tw_cos[tw_idx]),
      .w_im_p0 (w_im),
      .vld_p1  (vld_p1),
      .a_re_p1 (ar_p1),
      .a_im_p1 (ai_p1),
      .b_re_p1 (br_p1),
      .b_im_p1 (bi_p1)
   );

   // ---- p0 -> p1: write-back addresses follow the butterfly ----
   always_ff @(posedge clk) begin
      wa_p1 <= a_idx;
      wb_p1 <= b_idx;
   end

   // Sample memory: bit-reversed load, in-place butterfly write-back.
   // Consecutive butterflies never share addresses, so the one-cycle
   // write-back delay needs no forwarding.
   always_ff @(posedge clk) begin
      if (load_fire) begin
         mem_re[br_idx] <= in_re;
         mem_im[br_idx] <= in_im;
      end
      if (vld_p1) begin
         mem_re[wa_p1] <= ar_p1;
         mem_im[wa_p1] <= ai_p1;
         mem_re[wb_p1] <= br_p1;
         mem_im[wb_p1] <= bi_p1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // FSM next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = LOAD;
         LOAD:    if (load_fire && (load_idx == LAST_IDX)) state_nx = COMPUTE;
         COMPUTE: if (last_bf) state_nx = UNLOAD;
         UNLOAD:  if (out_fire && (out_idx == LAST_IDX)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM decoded outputs.
   always_comb begin
      in_ready = (state == LOAD);
      busy     = (state != IDLE);
   end

   // Counters, mode latch and the registered output port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inv_q     <= 1'b0;
         load_idx  <= '0;
         out_idx   <= '0;
         s_cnt     <= '0;
         j_cnt     <= '0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               load_idx <= '0;
               if (start) inv_q <= inverse;
            end
            LOAD: if (load_fire) load_idx <= load_idx + 1'b1;
            COMPUTE: begin
               j_cnt <= j_cnt + 1'b1;
               if (j_cnt == LAST_J) s_cnt <= (s_cnt == LAST_S) ? '0 : s_cnt + 1'b1;
               if (last_bf) begin
                  out_valid <= 1'b1;
                  out_idx   <= '0;
                  out_re    <= mem_re[0];
                  out_im    <= mem_im[0];
               end
            end
            UNLOAD: if (out_fire) begin
               if (out_idx == LAST_IDX) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  out_idx <= out_idx + 1'b1;
                  out_re  <= mem_re[out_idx + 1'b1];
                  out_im  <= mem_im[out_idx + 1'b1];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
